// File: rtl/fb_pkg.sv
// Shared types and helpers for the single-clock frame buffer.
package fb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    localparam logic [11:0] FB_FILL_DEFAULT = 12'h000;

    function automatic int img_size(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/fb_clear_fsm.sv
// Clear engine: sweeps addresses 0..IMG_SIZE-1 with one fill write per cycle.
module fb_clear_fsm
    import fb_pkg::*;
#(
    parameter int AW       = 15,
    parameter int IMG_SIZE = 19200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_start,
    output logic          busy,
    output logic [AW-1:0] clr_addr,
    output fb_state_t     state
);

    localparam logic [AW-1:0] LAST = AW'(IMG_SIZE - 1);

    fb_state_t     state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;

    // Reset lands directly in CLEAR so memory contents are defined after power-up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (clear_start) begin
                    cnt_nxt = '0;
                end else if (cnt == LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/frame_buffer_proc.sv
// Single-clock frame buffer: capture write, VGA read and a read-modify-write
// processing port sharing one RAM write port via a one-entry pending buffer.
module frame_buffer_proc
    import fb_pkg::*;
#(
    parameter int            AW    = 15,
    parameter int            DW    = 12,
    parameter int            IMG_W = 160,
    parameter int            IMG_H = 120,
    parameter logic [DW-1:0] FILL  = DW'(FB_FILL_DEFAULT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap_we,
    input  logic [AW-1:0] cap_addr,
    input  logic [DW-1:0] cap_data,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_data,
    input  logic          proc_rd,
    input  logic [AW-1:0] proc_addr,
    output logic [DW-1:0] proc_rd_data,
    output logic          proc_rd_valid,
    input  logic          proc_we,
    input  logic [DW-1:0] proc_wdata,
    output logic          proc_wr_ready,
    input  logic          clear_start,
    output logic          busy,
    output logic [7:0]    drop_cnt
);

    localparam int             NPOS     = 2 ** AW;
    localparam int             IMG_SIZE = img_size(IMG_W, IMG_H);
    localparam logic [AW:0]    IMG_LIM  = (AW + 1)'(IMG_SIZE);

    generate
        if (IMG_SIZE > NPOS) begin : g_size_chk
            $error("frame_buffer_proc: IMG_W*IMG_H exceeds 2**AW");
        end
    endgenerate

    fb_state_t     clr_state;
    logic [AW-1:0] clr_addr;
    logic          clr_we;

    fb_clear_fsm #(.AW(AW), .IMG_SIZE(IMG_SIZE)) u_clear (
        .clk         (clk),
        .reset       (reset),
        .clear_start (clear_start),
        .busy        (busy),
        .clr_addr    (clr_addr),
        .state       (clr_state)
    );

    assign clr_we = (clr_state == CLEAR);

    logic          cap_in, proc_in, vga_in;
    logic          cap_wr, proc_acc, pend_load, pend_ret, proc_direct;
    logic          pend_valid;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] mem [NPOS];

    assign cap_in  = ({1'b0, cap_addr} < IMG_LIM);
    assign proc_in = ({1'b0, proc_addr} < IMG_LIM);
    assign vga_in  = ({1'b0, vga_addr} < IMG_LIM);

    // Proc write handshake: a write transfers on any edge where proc_we and
    // proc_wr_ready are both high; otherwise the source holds proc_we/addr/data.
    assign proc_wr_ready = !busy && !pend_valid;
    assign cap_wr        = cap_we && !busy && cap_in;
    assign proc_acc      = proc_we && proc_wr_ready && proc_in;
    assign pend_load     = proc_acc && cap_wr;
    assign proc_direct   = proc_acc && !cap_wr;
    assign pend_ret      = pend_valid && !busy && !cap_wr;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_addr;
        ram_wdata = FILL;
        if (clr_we) begin
            ram_we = 1'b1;
        end else if (cap_wr) begin
            ram_we    = 1'b1;
            ram_waddr = cap_addr;
            ram_wdata = cap_data;
        end else if (pend_ret) begin
            ram_we    = 1'b1;
            ram_waddr = pend_addr;
            ram_wdata = pend_data;
        end else if (proc_direct) begin
            ram_we    = 1'b1;
            ram_waddr = proc_addr;
            ram_wdata = proc_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            drop_cnt   <= '0;
        end else begin
            if (pend_load) begin
                pend_valid <= 1'b1;
                pend_addr  <= proc_addr;
                pend_data  <= proc_wdata;
            end else if (pend_ret) begin
                pend_valid <= 1'b0;
            end
            if (cap_we && busy && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // Reads see pre-edge memory (read-first); the pending entry shadows its address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_data      <= '0;
            proc_rd_data  <= '0;
            proc_rd_valid <= 1'b0;
        end else begin
            vga_data      <= (busy || !vga_in) ? FILL : mem[vga_addr];
            proc_rd_valid <= proc_rd;
            if (proc_rd) begin
                if (busy || !proc_in) begin
                    proc_rd_data <= FILL;
                end else if (pend_valid && (pend_addr == proc_addr)) begin
                    proc_rd_data <= pend_data;
                end else begin
                    proc_rd_data <= mem[proc_addr];
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_proc.sv
// Self-checking bench for frame_buffer_proc with default parameters (160x120, RGB444).
module tb_frame_buffer_proc;

    localparam int AW       = 15;
    localparam int DW       = 12;
    localparam int IMG_SIZE = 160 * 120;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          proc_rd;
    logic [AW-1:0] proc_addr;
    logic [DW-1:0] proc_rd_data;
    logic          proc_rd_valid;
    logic          proc_we;
    logic [DW-1:0] proc_wdata;
    logic          proc_wr_ready;
    logic          clear_start;
    logic          busy;
    logic [7:0]    drop_cnt;

    frame_buffer_proc dut (
        .clk           (clk),
        .reset         (reset),
        .cap_we        (cap_we),
        .cap_addr      (cap_addr),
        .cap_data      (cap_data),
        .vga_addr      (vga_addr),
        .vga_data      (vga_data),
        .proc_rd       (proc_rd),
        .proc_addr     (proc_addr),
        .proc_rd_data  (proc_rd_data),
        .proc_rd_valid (proc_rd_valid),
        .proc_we       (proc_we),
        .proc_wdata    (proc_wdata),
        .proc_wr_ready (proc_wr_ready),
        .clear_start   (clear_start),
        .busy          (busy),
        .drop_cnt      (drop_cnt)
    );

    // scoreboard
    int            n_vec = 0;
    int            n_err = 0;
    logic [DW-1:0] vga_q[$];
    logic [DW-1:0] proc_q[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic cap_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cap_we   = 1'b1;
        cap_addr = a;
        cap_data = d;
        step();
        cap_we = 1'b0;
    endtask

    task automatic vga_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        vga_addr = a;
        vga_q.push_back(e);
        step();
        check("vga_data", vga_data, vga_q.pop_front());
    endtask

    task automatic proc_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        proc_rd   = 1'b1;
        proc_addr = a;
        proc_q.push_back(e);
        step();
        proc_rd = 1'b0;
        check("proc_rd_valid", proc_rd_valid, 1);
        check("proc_rd_data", proc_rd_data, proc_q.pop_front());
    endtask

    task automatic wait_clear(output int cycles, output int rdy_hi);
        cycles = 0;
        rdy_hi = 0;
        while (busy && cycles < 30000) begin
            if (proc_wr_ready) rdy_hi++;
            step();
            cycles++;
        end
    endtask

    initial begin
        int cyc;
        int rh;
        int bad;

        vecs[0] = '{15'd100,   12'hABC, 12'hABC};
        vecs[1] = '{15'd0,     12'h123, 12'h123};
        vecs[2] = '{15'd19199, 12'h5A5, 12'h5A5};
        vecs[3] = '{15'd160,   12'h0F0, 12'h0F0};
        vecs[4] = '{15'd19200, 12'hFFF, 12'h000};
        vecs[5] = '{15'd32767, 12'h777, 12'h000};

        reset       = 1'b1;
        cap_we      = 1'b0;
        cap_addr    = '0;
        cap_data    = '0;
        vga_addr    = '0;
        proc_rd     = 1'b0;
        proc_addr   = '0;
        proc_we     = 1'b0;
        proc_wdata  = '0;
        clear_start = 1'b0;
        step();
        step();

        check("rst_vga_data", vga_data, 0);
        check("rst_proc_rd_data", proc_rd_data, 0);
        check("rst_proc_rd_valid", proc_rd_valid, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_busy", busy, 1);
        check("rst_wr_ready", proc_wr_ready, 0);

        // power-up clear
        reset = 1'b0;
        wait_clear(cyc, rh);
        check("init_clear_cycles", cyc, IMG_SIZE);
        check("init_busy_low", busy, 0);
        check("init_drop_cnt", drop_cnt, 0);

        bad = 0;
        for (int a = 0; a < IMG_SIZE; a++) begin
            vga_addr = AW'(a);
            step();
            if (vga_data !== 12'h000) bad++;
        end
        check("clear_scan_nonzero", bad, 0);

        // capture writes / reads, table driven
        cap_write(vecs[0].addr, vecs[0].data);
        vga_read(vecs[0].addr, vecs[0].exp);
        for (int i = 1; i < 6; i++) cap_write(vecs[i].addr, vecs[i].data);
        for (int i = 0; i < 6; i++) begin
            vga_read(vecs[i].addr, vecs[i].exp);
            proc_read(vecs[i].addr, vecs[i].exp);
        end

        // capture and proc write collide: proc write parks in pending buffer
        cap_we     = 1'b1;
        cap_addr   = 15'd5;
        cap_data   = 12'h111;
        proc_we    = 1'b1;
        proc_addr  = 15'd6;
        proc_wdata = 12'h222;
        check("conflict_ready_accept", proc_wr_ready, 1);
        step();
        cap_we  = 1'b0;
        proc_we = 1'b0;
        check("conflict_ready_retire", proc_wr_ready, 0);
        proc_read(15'd6, 12'h222);
        check("conflict_ready_after", proc_wr_ready, 1);
        proc_read(15'd5, 12'h111);
        vga_read(15'd6, 12'h222);

        // pending entry waits while capture keeps the port busy
        cap_we     = 1'b1;
        cap_addr   = 15'd20;
        cap_data   = 12'h020;
        proc_we    = 1'b1;
        proc_addr  = 15'd21;
        proc_wdata = 12'h321;
        step();
        proc_we  = 1'b0;
        cap_addr = 15'd22;
        cap_data = 12'h022;
        check("pend_hold_ready", proc_wr_ready, 0);
        step();
        cap_we = 1'b0;
        check("pend_retire_ready", proc_wr_ready, 0);
        step();
        check("pend_done_ready", proc_wr_ready, 1);
        proc_read(15'd21, 12'h321);
        proc_read(15'd22, 12'h022);
        vga_read(15'd20, 12'h020);

        // out-of-image proc write alongside capture is discarded, no pending entry
        cap_we     = 1'b1;
        cap_addr   = 15'd30;
        cap_data   = 12'h030;
        proc_we    = 1'b1;
        proc_addr  = 15'd19300;
        proc_wdata = 12'hEEE;
        step();
        cap_we  = 1'b0;
        proc_we = 1'b0;
        check("oob_proc_no_pend", proc_wr_ready, 1);
        proc_read(15'd19300, 12'h000);

        // commanded clear with dropped captures
        for (int a = 0; a < 10; a++) cap_write(AW'(a), 12'hFFF);
        vga_read(15'd9, 12'hFFF);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        check("cmd_clear_busy", busy, 1);
        cap_we   = 1'b1;
        cap_addr = 15'd3;
        cap_data = 12'hABC;
        for (int i = 0; i < 300; i++) step();
        cap_we = 1'b0;
        check("drop_cnt_sat", drop_cnt, 255);
        vga_read(15'd19199, 12'h000);
        proc_read(15'd19199, 12'h000);
        wait_clear(cyc, rh);
        check("cmd_clear_cycles", cyc + 302, IMG_SIZE);
        for (int a = 0; a < 10; a++) vga_read(AW'(a), 12'h000);
        check("drop_cnt_hold", drop_cnt, 255);

        // reset in the middle of a clear restarts it; proc write held meanwhile
        cap_write(15'd100, 12'hABC);
        proc_read(15'd100, 12'hABC);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int i = 0; i < 5000; i++) step();
        check("mid_clear_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_proc_rd_data", proc_rd_data, 0);
        check("mid_rst_proc_rd_valid", proc_rd_valid, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_drop_cnt", drop_cnt, 0);
        step();
        proc_we    = 1'b1;
        proc_addr  = 15'd7;
        proc_wdata = 12'h7A7;
        reset      = 1'b0;
        wait_clear(cyc, rh);
        check("restart_clear_cycles", cyc, IMG_SIZE);
        check("held_write_ready_while_busy", rh, 0);
        check("held_write_ready_idle", proc_wr_ready, 1);
        step();
        proc_we = 1'b0;
        check("direct_write_ready", proc_wr_ready, 1);
        proc_read(15'd7, 12'h7A7);
        vga_read(15'd7, 12'h7A7);
        vga_read(15'd100, 12'h000);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_buffer_proc.md
Name: frame_buffer_proc

Overview:
Single-clock, parametrised frame buffer that replaces the dual-clock capture/VGA RAM.
- Three ports: camera capture write, VGA read, and a processing read/write port.
- Processing is now read-modify-write capable. Conflicts on the single physical write port are arbitrated with a one-entry pending-write buffer.
- A hardware clear engine fills the image area with a fill colour after reset or on command, so no file-based initialisation is needed.

Parameters:
- AW, 15: address width; memory depth NPOS = 2**AW.
- DW, 12: pixel width (RGB444 by default).
- IMG_W, 160: image width in pixels.
- IMG_H, 120: image height in pixels.
- FILL, 0: pixel value used by clear and for out-of-image reads (black).

Ports:
- clk  in  1  system clock (25 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- cap_we  in  1  capture write strobe.
- cap_addr  in  AW  capture write address.
- cap_data  in  DW  capture pixel.
- vga_addr  in  AW  VGA read address.
- vga_data  out  DW  VGA pixel, registered.
- proc_rd  in  1  processing read request.
- proc_addr  in  AW  processing read/write address.
- proc_rd_data  out  DW  processing read data.
- proc_rd_valid  out  1  one-cycle pulse, proc_rd_data valid.
- proc_we  in  1  processing write request.
- proc_wdata  in  DW  processing write pixel.
- proc_wr_ready  out  1  processing write accepted this cycle when high.
- clear_start  in  1  one-cycle command to start a clear.
- busy  out  1  clear in progress.
- drop_cnt  out  8  saturating count of capture writes dropped during clear.

Behaviour:
- IMG_SIZE = IMG_W*IMG_H. Elaboration check: IMG_SIZE <= NPOS, otherwise error.
- Reset values: vga_data=0, proc_rd_data=0, proc_rd_valid=0, pending buffer empty, drop_cnt=0. FSM enters CLEAR with counter 0, so busy=1 out of reset.
- FSM IDLE:
  - clear_start -> CLEAR, counter=0.
- FSM CLEAR:
  - Each cycle writes FILL at counter, then counter+1.
  - When counter==IMG_SIZE-1 is written -> IDLE; busy drops the next cycle.
  - clear_start while in CLEAR restarts the counter at 0.
  - Asynchronous reset mid-clear restarts the clear.
  - Total duration: IMG_SIZE cycles.
- Write-port priority: clear > capture > pending proc write > new proc write. Exactly one RAM write per cycle.
- Capture write:
  - cap_we in IDLE with cap_addr < IMG_SIZE: written this edge.
  - cap_addr >= IMG_SIZE: ignored.
  - cap_we while busy: dropped, drop_cnt+1, saturating at 255. drop_cnt clears only on reset.
- Proc write handshake:
  - proc_wr_ready = !busy && !pend_valid.
  - Write accepted when proc_we && proc_wr_ready.
  - If capture also writes that cycle, the proc write goes to the pending buffer (addr+data). The pending buffer retires on the first later cycle without capture; the retire cycle has proc_wr_ready low.
  - proc_we while not ready is ignored; the source must hold it.
  - Out-of-image proc address: accepted, discarded.
- Reads: synchronous, latency 1 on both read ports, read-first on a same-cycle write (returns old data).
  - Address >= IMG_SIZE returns FILL.
  - While busy, all reads return FILL.
  - Proc read hitting the pending-buffer address returns the pending data (forwarding).
  - proc_rd_valid = proc_rd registered, also while busy.
- VGA read has no stall and updates every cycle.

Decomposition:
- Package fb_pkg holds: state enum (IDLE, CLEAR), the IMG_SIZE function, and DW-wide FILL default.
- One natural sub-module: fb_clear_fsm, containing the counter, busy and the clear write request.
- Arbitration, pending buffer and RAM array stay in the top module.

Test Plan:
- Reset released -> busy=1 for exactly 19200 cycles; afterwards vga_addr=0..19199 reads 12'h000; drop_cnt=0.
- IDLE, cap_we addr=100 data=12'hABC; next cycle vga_addr=100 -> vga_data=12'hABC one cycle later. vga_addr=19200 -> 12'h000.
- Same cycle cap_we addr=5 data=12'h111 and proc_we addr=6 data=12'h222 -> proc_wr_ready=1 on acceptance, then 0 for the retire cycle. proc_rd addr=6 the next cycle returns 12'h222 with proc_rd_valid pulse; addr 5 reads 12'h111.
- clear_start after filling addr 0..9 with 12'hFFF; cap_we pulsed 300 times during clear -> drop_cnt=255; after busy falls, addr 0..9 read 12'h000.
- Reset asserted at clear cycle 5000 -> busy stays 1, clear restarts, 19200 further cycles to IDLE; proc_rd_data=0 during reset.
- proc_we addr=7 held while busy -> not written until busy falls, then accepted; read-back returns the written value.
